// File: rtl/knap_pkg.sv
// Shared types and constants for the knapsack exhaustive-search slice.
// Holds the controller state enum and the default item count.
package knap_pkg;

    localparam int KNAP_N_ITEMS = 5;

    localparam logic [KNAP_N_ITEMS-1:0] KNAP_CAND_MAX =
        KNAP_N_ITEMS'((1 << KNAP_N_ITEMS) - 1);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } knap_search_state_t;

endpackage

// File: rtl/knap_sol_reg.sv
// Single-entry ready/valid hold register for one solution vector.
// free is high when a load this cycle cannot overwrite unconsumed data.
module knap_sol_reg #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         free
);

    assign free = !valid || ready;

    // Valid flag: clear wins, then load, then drop on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    // Data is only written on a load so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (load && !clear) begin
            data <= din;
        end
    end

endmodule

// File: rtl/knap_search_ctrl.sv
// Exhaustive-search controller driving a knapsack validity checker.
// Define KNAP_SEARCH_FIRST_ONLY_EN to stop the sweep at the first solution.
module knap_search_ctrl
    import knap_pkg::*;
#(
    parameter int N_ITEMS = KNAP_N_ITEMS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic [N_ITEMS-1:0] cand,
    input  logic               chk_valid,
    output logic               sol_valid,
    input  logic               sol_ready,
    output logic [N_ITEMS-1:0] sol_data,
    output logic [N_ITEMS:0]   sol_count,
    output logic               busy,
    output logic               done
);

    localparam logic [N_ITEMS-1:0] CAND_LAST = '1;
    localparam logic [N_ITEMS:0]   CNT_MAX   = {1'b1, {N_ITEMS{1'b0}}};

    knap_search_state_t state, state_n;

    logic sol_free;
    logic sol_load;
    logic sol_clear;
    logic cand_clr;
    logic cand_adv;
    logic last;

    assign last = (cand == CAND_LAST);
    assign busy = (state == SWEEP) || (state == DRAIN);

    knap_sol_reg #(
        .W(N_ITEMS)
    ) u_sol_reg (
        .clk  (clk),
        .rst  (rst),
        .load (sol_load),
        .clear(sol_clear),
        .din  (cand),
        .ready(sol_ready),
        .valid(sol_valid),
        .data (sol_data),
        .free (sol_free)
    );

    // Next-state and datapath controls; abort overrides everything.
    always_comb begin
        state_n   = state;
        sol_load  = 1'b0;
        sol_clear = 1'b0;
        cand_clr  = 1'b0;
        cand_adv  = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n  = SWEEP;
                    cand_clr = 1'b1;
                end
            end
            SWEEP: begin
                if (chk_valid) begin
                    if (sol_free) begin
                        sol_load = 1'b1;
`ifdef KNAP_SEARCH_FIRST_ONLY_EN
                        state_n = DRAIN;
`else
                        if (last) begin
                            state_n = DRAIN;
                        end else begin
                            cand_adv = 1'b1;
                        end
`endif
                    end
                end else if (last) begin
                    state_n = sol_free ? DONE : DRAIN;
                end else begin
                    cand_adv = 1'b1;
                end
            end
            DRAIN: begin
                if (sol_free) begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n   = IDLE;
            sol_load  = 1'b0;
            sol_clear = 1'b1;
            cand_clr  = 1'b0;
            cand_adv  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Candidate counter; holds at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand <= '0;
        end else if (cand_clr) begin
            cand <= '0;
        end else if (cand_adv) begin
            cand <= cand + 1'b1;
        end
    end

    // Solution counter, saturating at 2^N_ITEMS.
    always_ff @(posedge clk) begin
        if (rst) begin
            sol_count <= '0;
        end else if (cand_clr) begin
            sol_count <= '0;
        end else if (sol_load && (sol_count != CNT_MAX)) begin
            sol_count <= sol_count + 1'b1;
        end
    end

    // One-cycle done pulse on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state_n == DONE) && (state != DONE);
        end
    end

endmodule
